// File: rtl/lpif_txrx_asym_gearbox_if.sv
// ---------------------------------------------------------------------------
// lpif_txrx_asym_gearbox_if
// Bundles the LPIF flit side and the logic-link FIFO side of the gearbox.
//   dstrm_*            : LPIF flit offered toward the link (push/ready handshake)
//   txfifo_downstream_*: narrow beats toward the TX FIFO (vld/ready)
//   rxfifo_upstream_*  : narrow beats from the RX FIFO (vld only)
//   ustrm_*            : reassembled LPIF flit with one-cycle strobe
//   rx_align_err*      : framing error pulse and saturating count
// modport slave  : the gearbox itself
// modport master : the adapter / FIFO side that surrounds it
// ---------------------------------------------------------------------------
interface lpif_txrx_asym_gearbox_if #(
    parameter int DATA_W   = 256,
    parameter int PROTID_W = 2,
    parameter int CRC_W    = 16,
    parameter int RATIO    = 2
);
    localparam int FLIT_W = 4 + PROTID_W + DATA_W + CRC_W + 3;
    localparam int LANE_W = (FLIT_W + RATIO - 1) / RATIO;
    localparam int BEAT_W = LANE_W + 1;

    logic [3:0]          dstrm_state;
    logic [PROTID_W-1:0] dstrm_protid;
    logic [DATA_W-1:0]   dstrm_data;
    logic                dstrm_dvalid;
    logic [CRC_W-1:0]    dstrm_crc;
    logic                dstrm_crc_valid;
    logic                dstrm_valid;
    logic                dstrm_push;
    logic                dstrm_ready;

    logic [BEAT_W-1:0]   txfifo_downstream_data;
    logic                txfifo_downstream_vld;
    logic                txfifo_downstream_ready;

    logic [BEAT_W-1:0]   rxfifo_upstream_data;
    logic                rxfifo_upstream_vld;

    logic [3:0]          ustrm_state;
    logic [PROTID_W-1:0] ustrm_protid;
    logic [DATA_W-1:0]   ustrm_data;
    logic                ustrm_dvalid;
    logic [CRC_W-1:0]    ustrm_crc;
    logic                ustrm_crc_valid;
    logic                ustrm_valid;
    logic                ustrm_flit_vld;

    logic                rx_align_err;
    logic [7:0]          rx_align_err_cnt;

    modport slave (
        input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
               dstrm_crc_valid, dstrm_valid, dstrm_push,
               txfifo_downstream_ready, rxfifo_upstream_data, rxfifo_upstream_vld,
        output dstrm_ready, txfifo_downstream_data, txfifo_downstream_vld,
               ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
               ustrm_crc_valid, ustrm_valid, ustrm_flit_vld,
               rx_align_err, rx_align_err_cnt
    );

    modport master (
        output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
               dstrm_crc_valid, dstrm_valid, dstrm_push,
               txfifo_downstream_ready, rxfifo_upstream_data, rxfifo_upstream_vld,
        input  dstrm_ready, txfifo_downstream_data, txfifo_downstream_vld,
               ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
               ustrm_crc_valid, ustrm_valid, ustrm_flit_vld,
               rx_align_err, rx_align_err_cnt
    );
endinterface

// File: rtl/lpif_txrx_asym_gearbox.sv
// ---------------------------------------------------------------------------
// lpif_txrx_asym_gearbox
// TX: packs one LPIF flit into FLIT_W bits and serialises it into RATIO beats
//     of LANE_W payload bits plus a mark bit (bit 0, set on beat 0 only).
// RX: realigns on the mark bit, collects RATIO beats and presents the flit
//     on registered ustrm_* fields with a one-cycle ustrm_flit_vld strobe.
// Ports: clk_wr (single clock), rst_wr_n (synchronous, active low),
//        bus (slave side of lpif_txrx_asym_gearbox_if).
// RATIO must be 1, 2 or 4.
// ---------------------------------------------------------------------------
module lpif_txrx_asym_gearbox #(
    parameter int DATA_W   = 256,
    parameter int PROTID_W = 2,
    parameter int CRC_W    = 16,
    parameter int RATIO    = 2
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr_n,
    lpif_txrx_asym_gearbox_if.slave   bus
);
    localparam int FLIT_W = 4 + PROTID_W + DATA_W + CRC_W + 3;
    localparam int LANE_W = (FLIT_W + RATIO - 1) / RATIO;
    localparam int BEAT_W = LANE_W + 1;
    localparam int PAD_W  = RATIO * LANE_W;
    localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

    // ------------------------------------------------------------------ TX
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    tx_state_e          tx_state, tx_state_d;
    logic [CNT_W-1:0]   tx_cnt, tx_cnt_nxt;
    logic [PAD_W-1:0]   tx_flit, tx_flit_d;
    logic               tx_last, tx_adv, tx_accept;

    always_comb begin
        tx_flit_d  = PAD_W'({bus.dstrm_valid, bus.dstrm_crc_valid, bus.dstrm_crc,
                             bus.dstrm_dvalid, bus.dstrm_data, bus.dstrm_protid,
                             bus.dstrm_state});
        tx_last    = (tx_cnt == CNT_W'(RATIO - 1));
        tx_adv     = (tx_state == TX_SEND) && bus.txfifo_downstream_ready;
        // Accepting on the last beat's ready keeps flits back-to-back.
        bus.dstrm_ready = (tx_state == TX_IDLE) || (tx_adv && tx_last);
        tx_accept  = bus.dstrm_push && bus.dstrm_ready;
        tx_cnt_nxt = tx_last ? '0 : tx_cnt + 1'b1;
        tx_state_d = tx_state;
        if (tx_accept)
            tx_state_d = TX_SEND;
        else if (tx_adv && tx_last)
            tx_state_d = TX_IDLE;
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            tx_state                   <= TX_IDLE;
            tx_cnt                     <= '0;
            tx_flit                    <= '0;
            bus.txfifo_downstream_data <= '0;
            bus.txfifo_downstream_vld  <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            if (tx_accept) begin
                tx_flit                    <= tx_flit_d;
                tx_cnt                     <= '0;
                bus.txfifo_downstream_data <= {tx_flit_d[LANE_W-1:0], 1'b1};
                bus.txfifo_downstream_vld  <= 1'b1;
            end else if (tx_adv) begin
                tx_cnt                    <= tx_cnt_nxt;
                bus.txfifo_downstream_vld <= !tx_last;
                if (!tx_last)
                    bus.txfifo_downstream_data <=
                        {tx_flit[int'(tx_cnt_nxt)*LANE_W +: LANE_W], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------ RX
    logic [CNT_W-1:0]   rx_cnt, rx_slot;
    logic [PAD_W-1:0]   rx_buf, rx_asm;
    logic [FLIT_W-1:0]  rx_flit;
    logic [LANE_W-1:0]  rx_slice;
    logic               rx_mark, rx_drop, rx_err, rx_done;

    always_comb begin
        rx_mark  = bus.rxfifo_upstream_data[0];
        rx_slice = bus.rxfifo_upstream_data[BEAT_W-1:1];
        // A mark always restarts the flit; an unmarked beat with nothing
        // in progress has no home and is dropped.
        rx_slot  = rx_mark ? '0 : rx_cnt;
        rx_drop  = !rx_mark && (rx_cnt == '0);
        rx_err   = bus.rxfifo_upstream_vld && (rx_drop || (rx_mark && rx_cnt != '0));
        rx_done  = bus.rxfifo_upstream_vld && !rx_drop && (rx_slot == CNT_W'(RATIO - 1));
        // Final slice is taken straight from the bus so the flit is
        // registered in the same cycle it completes.
        rx_asm   = rx_buf;
        rx_asm[(RATIO-1)*LANE_W +: LANE_W] = rx_slice;
        rx_flit  = FLIT_W'(rx_asm);
    end

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            rx_cnt               <= '0;
            rx_buf               <= '0;
            bus.ustrm_state      <= '0;
            bus.ustrm_protid     <= '0;
            bus.ustrm_data       <= '0;
            bus.ustrm_dvalid     <= 1'b0;
            bus.ustrm_crc        <= '0;
            bus.ustrm_crc_valid  <= 1'b0;
            bus.ustrm_valid      <= 1'b0;
            bus.ustrm_flit_vld   <= 1'b0;
            bus.rx_align_err     <= 1'b0;
            bus.rx_align_err_cnt <= '0;
        end else begin
            bus.ustrm_flit_vld <= rx_done;
            bus.rx_align_err   <= rx_err;
            if (rx_err && bus.rx_align_err_cnt != 8'hFF)
                bus.rx_align_err_cnt <= bus.rx_align_err_cnt + 8'd1;
            if (bus.rxfifo_upstream_vld && !rx_drop) begin
                rx_buf[int'(rx_slot)*LANE_W +: LANE_W] <= rx_slice;
                rx_cnt <= rx_done ? '0 : rx_slot + 1'b1;
            end
            if (rx_done) begin
                bus.ustrm_state     <= rx_flit[3:0];
                bus.ustrm_protid    <= rx_flit[4 +: PROTID_W];
                bus.ustrm_data      <= rx_flit[4+PROTID_W +: DATA_W];
                bus.ustrm_dvalid    <= rx_flit[4+PROTID_W+DATA_W];
                bus.ustrm_crc       <= rx_flit[5+PROTID_W+DATA_W +: CRC_W];
                bus.ustrm_crc_valid <= rx_flit[FLIT_W-2];
                bus.ustrm_valid     <= rx_flit[FLIT_W-1];
            end
        end
    end
endmodule
